layer_scheduler: RTL and testbench

//  Sequences CNN layers onto the engine: buffers layer descriptors in a command FIFO,

---
 rtl/layer_scheduler_pkg.sv | 45 ++++
 rtl/layer_scheduler_cmd_fifo.sv | 74 +++++++
 rtl/layer_scheduler.sv | 170 +++++++++++++++++
 tb/tb_layer_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_scheduler_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : layer_scheduler_pkg
//  Purpose  : Shared types and constants for the CNN layer scheduler:
//             descriptor layout, engine op codes, FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package layer_scheduler_pkg;

    localparam int c_cmd_w = 104;

    localparam logic [2:0] c_op_cmac = 3'd1;
    localparam logic [2:0] c_op_scmp = 3'd2;
    localparam logic [2:0] c_op_sacc = 3'd3;

    // Descriptor layout, MSB first; total width is c_cmd_w bits.
    typedef struct packed {
        logic        last;
        logic [2:0]  op_type;
        logic [3:0]  stride;
        logic [15:0] stride2;
        logic [7:0]  kernel;
        logic [7:0]  kernel_size;
        logic [15:0] i_channel;
        logic [15:0] o_channel;
        logic [7:0]  i_side;
        logic [7:0]  o_side;
        logic [15:0] bias;
    } cmd_desc_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH    = 2'd1,
        S_WAIT_RDY = 2'd2,
        S_RUN      = 2'd3
    } sched_state_t;

    // Only the three engine operations are executable; anything else is dropped.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == c_op_cmac) || (op == c_op_scmp) || (op == c_op_sacc);
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_scheduler_cmd_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : layer_scheduler_cmd_fifo
//  Purpose  : Synchronous descriptor FIFO with flush. Head entry is read from
//             flop storage. Push and pop in the same cycle are allowed when
//             full; a push coinciding with flush lands in the emptied FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module layer_scheduler_cmd_fifo #(
    parameter int WIDTH = 104,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw:0] c_full_cnt = (c_aw+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;

    logic            w_do_pop;
    logic            w_do_push;
    logic [c_aw-1:0] w_wr_idx;

    assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;
    assign w_do_push = i_push && (i_flush || (r_count != c_full_cnt) || w_do_pop);
    assign w_wr_idx  = i_flush ? '0 : r_wr_ptr;

    // Storage write; no reset needed since occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush restarts from slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= w_do_push ? c_aw'(1) : '0;
            r_count  <= {{c_aw{1'b0}}, w_do_push};
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = (r_count == c_full_cnt);
    assign o_empty   = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/layer_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : layer_scheduler
//  Purpose  : Queues CNN layer descriptors, presents each legal one to the
//             engine with a valid/ready/finish handshake, counts completed
//             layers and reports illegal ops and watchdog timeouts.
//  Revision : 1.0  initial release
// ============================================================================
module layer_scheduler #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 2**20,
    parameter int CMD_W   = 104
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] cmd_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             run_en,
    input  logic             abort,
    input  logic             engine_ready,
    input  logic             gemm_finish,
    output logic             engine_valid,
    output logic [2:0]       op_type,
    output logic [3:0]       stride,
    output logic [15:0]      stride2,
    output logic [7:0]       kernel,
    output logic [7:0]       kernel_size,
    output logic [15:0]      i_channel,
    output logic [15:0]      o_channel,
    output logic [7:0]       i_side,
    output logic [7:0]       o_side,
    output logic [15:0]      bias,
    output logic             busy,
    output logic             layer_done,
    output logic             seq_done,
    output logic [15:0]      layer_cnt,
    output logic             err_op,
    output logic             err_timeout
);

    import layer_scheduler_pkg::*;

    localparam int c_wd_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);

    sched_state_t      r_state;
    sched_state_t      w_state_next;
    cmd_desc_t         r_cfg;
    cmd_desc_t         w_head;
    logic [CMD_W-1:0]  w_fifo_rd;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [c_wd_w-1:0] r_watchdog;
    logic              r_layer_done;
    logic              r_seq_done;
    logic [15:0]       r_layer_cnt;
    logic              r_err_op;
    logic              r_err_timeout;

    logic w_push;
    logic w_pop;
    logic w_fetch;
    logic w_head_legal;
    logic w_wd_expired;
    logic w_finish;
    logic w_timeout_fire;
    logic w_flush;

    assign w_head         = cmd_desc_t'(w_fifo_rd);
    assign w_head_legal   = op_is_legal(w_head.op_type);
    assign w_fetch        = (r_state == S_FETCH) && !abort;
    assign w_pop          = w_fetch;
    assign w_push         = cmd_valid && cmd_ready;
    assign w_wd_expired   = (r_watchdog == c_wd_last);
    // Finish beats the watchdog in the same cycle; abort beats both.
    assign w_finish       = (r_state == S_RUN) && gemm_finish && !abort;
    assign w_timeout_fire = (r_state == S_RUN) && !gemm_finish && w_wd_expired && !abort;
    assign w_flush        = abort || w_timeout_fire;

    assign cmd_ready = !w_fifo_full && !abort;

    layer_scheduler_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .i_wr_data (cmd_data),
        .o_rd_data (w_fifo_rd),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next-state logic; abort returns to IDLE from anywhere.
    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (run_en && !w_fifo_empty) w_state_next = S_FETCH;
                S_FETCH:    w_state_next = w_head_legal ? S_WAIT_RDY : S_IDLE;
                S_WAIT_RDY: if (engine_ready) w_state_next = S_RUN;
                S_RUN:      if (gemm_finish || w_wd_expired) w_state_next = S_IDLE;
                default:    w_state_next = S_IDLE;
            endcase
        end
    end

    // Config is captured only when the head is popped, so it is stable through RUN.
    always_ff @(posedge clk) begin
        if (rst)          r_cfg <= '0;
        else if (w_fetch) r_cfg <= w_head;
    end

    // Watchdog restarts on handoff to the engine and counts RUN cycles.
    always_ff @(posedge clk) begin
        if (rst)                                         r_watchdog <= '0;
        else if ((r_state == S_WAIT_RDY) && engine_ready) r_watchdog <= '0;
        else if (r_state == S_RUN)                       r_watchdog <= r_watchdog + c_wd_w'(1);
    end

    // Completion pulses, layer counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_layer_done  <= 1'b0;
            r_seq_done    <= 1'b0;
            r_layer_cnt   <= '0;
            r_err_op      <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_layer_done <= w_finish;
            r_seq_done   <= w_finish && r_cfg.last;
            if (w_finish)                 r_layer_cnt   <= r_layer_cnt + 16'd1;
            if (w_fetch && !w_head_legal) r_err_op      <= 1'b1;
            if (w_timeout_fire)           r_err_timeout <= 1'b1;
        end
    end

    assign engine_valid = (r_state == S_RUN);
    assign busy         = (r_state != S_IDLE);
    assign op_type      = r_cfg.op_type;
    assign stride       = r_cfg.stride;
    assign stride2      = r_cfg.stride2;
    assign kernel       = r_cfg.kernel;
    assign kernel_size  = r_cfg.kernel_size;
    assign i_channel    = r_cfg.i_channel;
    assign o_channel    = r_cfg.o_channel;
    assign i_side       = r_cfg.i_side;
    assign o_side       = r_cfg.o_side;
    assign bias         = r_cfg.bias;
    assign layer_done   = r_layer_done;
    assign seq_done     = r_seq_done;
    assign layer_cnt    = r_layer_cnt;
    assign err_op       = r_err_op;
    assign err_timeout  = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_layer_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_layer_scheduler
//  Purpose  : Self-checking bench for layer_scheduler. Main instance uses the
//             default watchdog; a second instance with TIMEOUT=64 shares the
//             stimulus and is observed for the watchdog scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_layer_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [103:0] cmd_data;
    logic         cmd_valid, run_en, abort, engine_ready, gemm_finish;

    logic         cmd_ready, engine_valid, busy, layer_done, seq_done, err_op, err_timeout;
    logic [2:0]   op_type;
    logic [3:0]   stride;
    logic [15:0]  stride2, i_channel, o_channel, bias, layer_cnt;
    logic [7:0]   kernel, kernel_size, i_side, o_side;

    logic         t_cmd_ready, t_engine_valid, t_busy, t_layer_done, t_seq_done, t_err_op, t_err_timeout;
    logic [2:0]   t_op_type;
    logic [3:0]   t_stride;
    logic [15:0]  t_stride2, t_i_channel, t_o_channel, t_bias, t_layer_cnt;
    logic [7:0]   t_kernel, t_kernel_size, t_i_side, t_o_side;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    layer_scheduler dut (
        .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .run_en(run_en), .abort(abort), .engine_ready(engine_ready), .gemm_finish(gemm_finish),
        .engine_valid(engine_valid), .op_type(op_type), .stride(stride), .stride2(stride2),
        .kernel(kernel), .kernel_size(kernel_size), .i_channel(i_channel), .o_channel(o_channel),
        .i_side(i_side), .o_side(o_side), .bias(bias), .busy(busy), .layer_done(layer_done),
        .seq_done(seq_done), .layer_cnt(layer_cnt), .err_op(err_op), .err_timeout(err_timeout)
    );

    layer_scheduler #(.TIMEOUT(64)) dut_t (
        .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(t_cmd_ready),
        .run_en(run_en), .abort(abort), .engine_ready(engine_ready), .gemm_finish(gemm_finish),
        .engine_valid(t_engine_valid), .op_type(t_op_type), .stride(t_stride), .stride2(t_stride2),
        .kernel(t_kernel), .kernel_size(t_kernel_size), .i_channel(t_i_channel), .o_channel(t_o_channel),
        .i_side(t_i_side), .o_side(t_o_side), .bias(t_bias), .busy(t_busy), .layer_done(t_layer_done),
        .seq_done(t_seq_done), .layer_cnt(t_layer_cnt), .err_op(t_err_op), .err_timeout(t_err_timeout)
    );

    typedef struct {
        logic [103:0] desc;
        logic         legal;
        int           run_cyc;
        logic [15:0]  exp_cnt;
        logic         exp_err_op;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [103:0] mk(input logic last, input logic [2:0] op, input logic [3:0] st,
                                        input logic [15:0] st2, input logic [7:0] k, input logic [7:0] ks,
                                        input logic [15:0] ic, input logic [15:0] oc, input logic [7:0] is,
                                        input logic [7:0] os, input logic [15:0] b);
        return {last, op, st, st2, k, ks, ic, oc, is, os, b};
    endfunction

    function automatic logic [102:0] cfg_bus();
        return {op_type, stride, stride2, kernel, kernel_size, i_channel, o_channel, i_side, o_side, bias};
    endfunction

    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; run_en = 1'b0; abort = 1'b0;
        engine_ready = 1'b0; gemm_finish = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [103:0] d);
        cmd_data = d; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Bounded wait for main-instance engine_valid; returns cycles waited.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!engine_valid && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int lat, gap, hi, seq_cnt;
        logic saw;

        vecs[0] = '{mk(1, 3'd1, 4'd2, 16'd6, 8'd3, 8'd9, 16'd3, 16'd1, 8'd7, 8'd4, 16'h4000), 1'b1, 200, 16'd1, 1'b0};
        vecs[1] = '{mk(0, 3'd5, 4'd1, 16'd1, 8'd1, 8'd1, 16'd1, 16'd1, 8'd1, 8'd1, 16'h0001), 1'b0, 0,   16'd1, 1'b1};
        vecs[2] = '{mk(0, 3'd2, 4'd1, 16'd2, 8'd5, 8'd25, 16'd8, 16'd16, 8'd14, 8'd12, 16'h1234), 1'b1, 10, 16'd2, 1'b1};
        vecs[3] = '{mk(1, 3'd3, 4'd3, 16'd9, 8'd1, 8'd1, 16'd64, 16'd64, 8'd28, 8'd28, 16'hBEEF), 1'b1, 1,   16'd3, 1'b1};
        vecs[4] = '{mk(1, 3'd0, 4'd0, 16'd0, 8'd0, 8'd0, 16'd0, 16'd0, 8'd0, 8'd0, 16'h0000), 1'b0, 0,   16'd3, 1'b1};
        vecs[5] = '{mk(0, 3'd1, 4'hF, 16'hFFFF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 16'hFFFF), 1'b1, 3, 16'd4, 1'b1};

        // Reset state
        do_reset();
        chk("rst_cmd_ready", 104'(cmd_ready), 104'd1);
        chk("rst_valid",     104'(engine_valid), 104'd0);
        chk("rst_busy",      104'(busy), 104'd0);
        chk("rst_cnt",       104'(layer_cnt), 104'd0);
        chk("rst_err",       104'({err_op, err_timeout, layer_done, seq_done}), 104'd0);
        chk("rst_cfg",       104'(cfg_bus()), 104'd0);

        // Table: one descriptor at a time, engine always ready
        run_en = 1'b1; engine_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].desc);
            if (vecs[i].legal) begin
                wait_valid(lat);
                chk($sformatf("v%0d_latency", i), 104'(lat), 104'd3);
                chk($sformatf("v%0d_cfg", i), 104'(cfg_bus()), 104'(vecs[i].desc[102:0]));
                repeat (vecs[i].run_cyc - 1) tick();
                chk($sformatf("v%0d_valid_held", i), 104'(engine_valid), 104'd1);
                chk($sformatf("v%0d_cfg_stable", i), 104'(cfg_bus()), 104'(vecs[i].desc[102:0]));
                gemm_finish = 1'b1;
                tick();
                gemm_finish = 1'b0;
                chk($sformatf("v%0d_valid_drop", i), 104'(engine_valid), 104'd0);
                chk($sformatf("v%0d_layer_done", i), 104'(layer_done), 104'd1);
                chk($sformatf("v%0d_seq_done", i), 104'(seq_done), 104'(vecs[i].desc[103]));
                chk($sformatf("v%0d_cnt", i), 104'(layer_cnt), 104'(vecs[i].exp_cnt));
                tick();
                chk($sformatf("v%0d_done_pulse", i), 104'({layer_done, seq_done}), 104'd0);
            end else begin
                saw = 1'b0;
                repeat (5) begin
                    tick();
                    if (engine_valid) saw = 1'b1;
                end
                chk($sformatf("v%0d_no_valid", i), 104'(saw), 104'd0);
                chk($sformatf("v%0d_busy", i), 104'(busy), 104'd0);
                chk($sformatf("v%0d_cnt", i), 104'(layer_cnt), 104'(vecs[i].exp_cnt));
            end
            chk($sformatf("v%0d_err_op", i), 104'(err_op), 104'(vecs[i].exp_err_op));
        end

        // Three queued layers: windows separated by exactly 3 idle cycles
        do_reset();
        engine_ready = 1'b1;
        gemm_finish = 1'b1;
        tick();
        gemm_finish = 1'b0;
        push(mk(0, 3'd1, 4'd1, 16'd1, 8'd3, 8'd9, 16'd1, 16'd1, 8'd8, 8'd8, 16'h0011));
        push(mk(0, 3'd2, 4'd1, 16'd1, 8'd3, 8'd9, 16'd2, 16'd2, 8'd8, 8'd8, 16'h0022));
        push(mk(1, 3'd3, 4'd1, 16'd1, 8'd3, 8'd9, 16'd3, 16'd3, 8'd8, 8'd8, 16'h0033));
        chk("t2_finish_outside_run", 104'({layer_cnt, layer_done}), 104'd0);
        run_en = 1'b1;
        seq_cnt = 0;
        gap = 0;
        for (int l = 0; l < 3; l++) begin
            if (l == 0) wait_valid(lat);
            else        chk($sformatf("t2_gap%0d", l), 104'(gap), 104'd3);
            chk($sformatf("t2_op%0d", l), 104'(op_type), 104'(l + 1));
            repeat (4) tick();
            gemm_finish = 1'b1;
            tick();
            gemm_finish = 1'b0;
            chk($sformatf("t2_done%0d", l), 104'(layer_done), 104'd1);
            if (seq_done) seq_cnt++;
            gap = 0;
            while (!engine_valid && gap < 20) begin
                gap++;
                tick();
            end
        end
        chk("t2_no_extra", 104'(engine_valid), 104'd0);
        chk("t2_seq_once", 104'(seq_cnt), 104'd1);
        chk("t2_cnt", 104'(layer_cnt), 104'd3);

        // FIFO full back-pressure and recovery after one pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cmd_data = mk(0, 3'd1, 4'd0, 16'(i), 8'd0, 8'd0, 16'd0, 16'd0, 8'd0, 8'd0, 16'(i));
            cmd_valid = 1'b1;
            chk($sformatf("t3_ready%0d", i), 104'(cmd_ready), 104'd1);
            tick();
        end
        chk("t3_ready_9th", 104'(cmd_ready), 104'd0);
        tick();
        cmd_valid = 1'b0;
        chk("t3_still_full", 104'(cmd_ready), 104'd0);
        run_en = 1'b1;
        tick();
        chk("t3_fetch_cycle", 104'(cmd_ready), 104'd0);
        tick();
        chk("t3_ready_back", 104'(cmd_ready), 104'd1);
        chk("t3_busy", 104'(busy), 104'd1);

        // Watchdog on the TIMEOUT=64 instance with two more descriptors queued
        do_reset();
        engine_ready = 1'b1;
        push(mk(0, 3'd1, 4'd1, 16'd1, 8'd1, 8'd1, 16'd1, 16'd1, 8'd1, 8'd1, 16'h0001));
        push(mk(0, 3'd2, 4'd1, 16'd1, 8'd1, 8'd1, 16'd1, 16'd1, 8'd1, 8'd1, 16'h0002));
        push(mk(0, 3'd3, 4'd1, 16'd1, 8'd1, 8'd1, 16'd1, 16'd1, 8'd1, 8'd1, 16'h0003));
        run_en = 1'b1;
        lat = 0;
        while (!t_engine_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk("t5_latency", 104'(lat), 104'd3);
        hi = 0;
        while (t_engine_valid && hi < 200) begin
            hi++;
            tick();
        end
        chk("t5_run_cycles", 104'(hi), 104'd64);
        chk("t5_err_timeout", 104'(t_err_timeout), 104'd1);
        chk("t5_busy", 104'(t_busy), 104'd0);
        chk("t5_cnt", 104'({t_layer_cnt, t_layer_done}), 104'd0);
        saw = 1'b0;
        repeat (5) begin
            tick();
            if (t_busy) saw = 1'b1;
        end
        chk("t5_fifo_flushed", 104'(saw), 104'd0);
        chk("t5_err_sticky", 104'(t_err_timeout), 104'd1);

        // Abort coinciding with gemm_finish, two descriptors queued
        do_reset();
        chk("t6_rst_clears_err", 104'(t_err_timeout), 104'd0);
        run_en = 1'b1; engine_ready = 1'b1;
        push(mk(1, 3'd1, 4'd1, 16'd1, 8'd1, 8'd1, 16'd1, 16'd1, 8'd1, 8'd1, 16'h00A1));
        wait_valid(lat);
        chk("t6_valid", 104'(engine_valid), 104'd1);
        push(mk(1, 3'd2, 4'd1, 16'd1, 8'd1, 8'd1, 16'd1, 16'd1, 8'd1, 8'd1, 16'h00A2));
        push(mk(1, 3'd3, 4'd1, 16'd1, 8'd1, 8'd1, 16'd1, 16'd1, 8'd1, 8'd1, 16'h00A3));
        gemm_finish = 1'b1; abort = 1'b1;
        #1;
        chk("t6_ready_abort_cycle", 104'(cmd_ready), 104'd0);
        tick();
        gemm_finish = 1'b0; abort = 1'b0;
        #1;
        chk("t6_no_layer_done", 104'({layer_done, seq_done}), 104'd0);
        chk("t6_valid_low", 104'(engine_valid), 104'd0);
        chk("t6_idle", 104'(busy), 104'd0);
        chk("t6_cnt_kept", 104'(layer_cnt), 104'd0);
        chk("t6_ready_back", 104'(cmd_ready), 104'd1);
        saw = 1'b0;
        repeat (5) begin
            tick();
            if (busy) saw = 1'b1;
        end
        chk("t6_fifo_empty", 104'(saw), 104'd0);

        // Reset in the middle of a layer
        push(mk(0, 3'd2, 4'd5, 16'd5, 8'd5, 8'd5, 16'd5, 16'd5, 8'd5, 8'd5, 16'h0555));
        wait_valid(lat);
        chk("t7_running", 104'(engine_valid), 104'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_valid", 104'(engine_valid), 104'd0);
        chk("t7_busy", 104'(busy), 104'd0);
        chk("t7_cfg", 104'(cfg_bus()), 104'd0);
        chk("t7_ready", 104'(cmd_ready), 104'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
